dmem_responder: RTL and testbench
=================================

# dmem_responder

- Memory-side responder for the pipelined core's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and holds it for a programmable number of wait states.
- Performs the access on an internal word-organised array with byte/half/word lanes and returns a single-cycle response pulse.
- The core's MEM stage stalls on the absence of `resp_valid`; this block replaces the zero-latency data memory so the hazard logic can be exercised with real memory latency.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; word index is `req_addr[31:2]`.
- `LATENCY`, 2: wait-state cycles between accept and response; legal range 0..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; asserting it low clears all state immediately.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_size` input 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` input 1: load zero-extends when 1, sign-extends when 0.
- `req_wdata` input 32: store data, right-aligned (bits [7:0] for a byte store).
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: load result, extended to 32 bits; 0 for stores and errors.
- `resp_err` output 1: request rejected (misaligned or out of range); qualified by `resp_valid`.

## Operation
- FSM with three states:
  - IDLE: `req_ready`=1.
  - BUSY: a counter counts down `LATENCY` cycles; `req_ready`=0.
  - RESP: `resp_valid`=1 for exactly one cycle; `req_ready`=1.
- Accept happens when `req_valid & req_ready`. At accept, `req_we`, `req_addr`, `req_size`, `req_unsigned` and `req_wdata` are captured; inputs may change afterwards.
- Transitions:
  - IDLE/RESP with accept → BUSY, or directly → RESP when `LATENCY`=0.
  - RESP without accept → IDLE.
  - BUSY with counter at 1 → RESP.
- The array access (read or write) occurs on the edge entering RESP. Stores therefore commit exactly once, at the end of the request's lifetime.
- Lane handling is little-endian, selected by `addr[1:0]`:
  - Byte: any offset.
  - Half: offset 0 or 2.
  - Word: offset 0.
  - Store: writes only the addressed bytes; other bytes keep their value.
  - Load: extracts the addressed bytes and extends them per `req_unsigned`.
- Error (feature-dependent): misaligned half/word, or `addr[31:2] >= DEPTH_WORDS`. An error produces no array write, `resp_rdata`=0 and `resp_err`=1.
- The array is not cleared by reset and powers up undefined. The bench initialises it by storing through the port.

## Timing
- Reset values: `req_ready`=0 while `reset` is low, then 1 from the first cycle after release (IDLE); `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Latency: request accepted in cycle t → `resp_valid` in cycle t+`LATENCY`+1.
- Throughput: back-to-back accept in the RESP cycle gives one response per `LATENCY`+1 cycles.
- `resp_rdata` and `resp_err` are registered and held only during the `resp_valid` cycle; they return to 0 afterwards.
- Reset during BUSY: the FSM returns to IDLE, the pending request is discarded, and a pending store is not committed.
- `req_valid` while `req_ready`=0: ignored; there is no queueing.
- Load to the same word as a store accepted on the previous RESP cycle: returns the new data, because the write commits before the next access.

## Configuration
- `DMEM_ERR_CHECK_EN`, defined:
  - Misalignment and range checking active as described.
  - Erroring requests are suppressed and flagged with `resp_err`.
- `DMEM_ERR_CHECK_EN`, undefined:
  - `resp_err` is tied 0.
  - Low address bits below the access size are forced to zero (word index masked to `clog2(DEPTH_WORDS)` bits, wrapping).
  - Every request performs an access.

## Structure
- Shared package `dmem_pkg`:
  - Size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
  - FSM state encodings `ST_IDLE`, `ST_BUSY`, `ST_RESP`.
  - Maximum `LATENCY` constant (15).
- One sub-module, `dmem_lane_align`, purely combinational:
  - Store path: produces a 4-bit byte-enable and the lane-shifted write data from size/offset/wdata.
  - Load path: extracts and extends from the raw word, size, offset and unsigned flag.
- The top level holds the FSM, wait-state counter, capture registers and array.

## Test plan
- Reset then word store 0xDEADBEEF @0x10, word load @0x10 with `LATENCY`=2 → `resp_valid` 3 cycles after each accept, load `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Byte store 0x80 @0x11, then load byte signed @0x11 → 0xFFFFFF80; unsigned → 0x00000080; word @0x10 → 0xDEAD80EF.
- Half load @0x12 signed after storing word 0x8001_0000 @0x10 → 0xFFFF8001; half load @0x13 → `resp_err`=1, `resp_rdata`=0 (with `DMEM_ERR_CHECK_EN`).
- `LATENCY`=0, hold `req_valid` high for 4 requests → responses on consecutive cycles after the first accept, `req_ready` never low.
- Word store 0x12345678 @0x20, assert `reset` low during BUSY, release, then load @0x20 → previous contents returned, no spurious `resp_valid` during or after reset.
- Store to `DEPTH_WORDS*4` → `resp_err`=1, array unchanged; with the macro undefined → the write lands at word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// the wait-state limit and the captured request record.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated write data for
// stores, byte/half extraction with sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  input  logic        uns,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata      = 32'h0;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata      = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata      = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Size 2'b11 behaves as a word access.
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata      = raw;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and a one-cycle response
// pulse. Define DMEM_ERR_CHECK_EN to flag misaligned / out-of-range requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        cap_q, cap_d;
  req_t        live, acc;
  logic        accept, do_access;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [AW-1:0] idx;
  logic [1:0]    offset;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wdata_lane, raw, load_data;
  logic [31:0]   mem [DEPTH_WORDS];

  assign live      = '{we: req_we, addr: req_addr, size: req_size,
                       uns: req_unsigned, wdata: req_wdata};
  assign req_ready = reset & (state_q != ST_BUSY);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    acc       = cap_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          cap_d = live;
          if (LATENCY == 0) begin
            // Zero wait states: the access uses the request as it arrives.
            state_d   = ST_RESP;
            acc       = live;
            do_access = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = 4'(LATENCY);
          end
        end else if (state_q == ST_RESP) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  assign offset = acc.addr[1:0];
  assign idx    = acc.addr[2 +: AW];

  always_comb begin
    err = ({2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS));
    case (acc.size)
      SZ_BYTE: ;
      SZ_HALF: if (offset[0]) err = 1'b1;
      default: if (offset != 2'b00) err = 1'b1;
    endcase
  end
`else
  logic unused_addr_hi;

  // Without checking, the address is forced into alignment and the index wraps.
  assign idx            = acc.addr[2 +: AW];
  assign err            = 1'b0;
  assign unused_addr_hi = ^acc.addr[31:2+AW];

  always_comb begin
    case (acc.size)
      SZ_BYTE: offset = acc.addr[1:0];
      SZ_HALF: offset = {acc.addr[1], 1'b0};
      default: offset = 2'b00;
    endcase
  end
`endif

  assign raw = mem[idx];

  dmem_lane_align u_lane (
    .size       (acc.size),
    .offset     (offset),
    .wdata      (acc.wdata),
    .raw        (raw),
    .uns        (acc.uns),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata      (load_data)
  );

  assign resp_rdata_d = (do_access & ~acc.we & ~err) ? load_data : 32'h0;
  assign resp_err_d   = do_access & err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cap_q        <= '0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // NOTE: the array has no reset; clearing it would force a flop-based memory.
  always_ff @(posedge clk) begin
    if (do_access & acc.we & ~err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of load/store vectors on a
// LATENCY=2 instance plus hand sequences for reset-in-BUSY and LATENCY=0 streaming.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_we, a_uns, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_size;
  logic        b_valid, b_ready, b_we, b_uns, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_size(a_size), .req_unsigned(a_uns),
    .req_wdata(a_wdata), .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_size(b_size), .req_unsigned(b_uns),
    .req_wdata(b_wdata), .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic drive_a(input vec_t v);
    a_we = v.we; a_addr = v.addr; a_size = v.size; a_uns = v.uns; a_wdata = v.wdata;
  endtask

  task automatic drive_b(input vec_t v);
    b_we = v.we; b_addr = v.addr; b_size = v.size; b_uns = v.uns; b_wdata = v.wdata;
  endtask

  // One request on the LATENCY=2 instance; lat counts cycles from accept to response.
  task automatic txn(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    drive_a(v);
    a_valid = 1'b1;
    guard = 0;
    while (!a_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_wdata = 32'h5A5A_5A5A;
    a_addr  = 32'hFFFF_FFFC;
    lat = 1;
    while (!a_rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = a_rdata;
    er = a_err;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(v, rd, er, lat);
    check({v.name, "_lat"}, 32'(lat), 32'd3);
    check({v.name, "_rdata"}, rd, v.exp_rdata);
    check({v.name, "_err"}, {31'b0, er}, {31'b0, v.exp_err});
    @(negedge clk);
    check({v.name, "_vld_drop"}, {31'b0, a_rvalid}, 32'd0);
    check({v.name, "_rdata_clr"}, a_rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t l0[4];

    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_size = '0; a_uns = 1'b0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_size = '0; b_uns = 1'b0; b_wdata = '0;

    add("st_w0",    1, 32'h0,  SZ_WORD, 0, 32'h0102_0304, 32'h0, 0);
    add("st_w10",   1, 32'h10, SZ_WORD, 0, 32'hDEAD_BEEF, 32'h0, 0);
    add("ld_w10",   0, 32'h10, SZ_WORD, 0, 32'h0,         32'hDEAD_BEEF, 0);
    add("st_b11",   1, 32'h11, SZ_BYTE, 0, 32'hFFFF_FF80, 32'h0, 0);
    add("ld_b11_s", 0, 32'h11, SZ_BYTE, 0, 32'h0,         32'hFFFF_FF80, 0);
    add("ld_b11_u", 0, 32'h11, SZ_BYTE, 1, 32'h0,         32'h0000_0080, 0);
    add("ld_w10_b", 0, 32'h10, SZ_WORD, 0, 32'h0,         32'hDEAD_80EF, 0);
    add("st_w10_2", 1, 32'h10, SZ_WORD, 0, 32'h8001_0000, 32'h0, 0);
    add("ld_h12_s", 0, 32'h12, SZ_HALF, 0, 32'h0,         32'hFFFF_8001, 0);
    add("ld_h12_u", 0, 32'h12, SZ_HALF, 1, 32'h0,         32'h0000_8001, 0);
    add("ld_h10_s", 0, 32'h10, SZ_HALF, 0, 32'h0,         32'h0000_0000, 0);
    add("ld_b13_s", 0, 32'h13, SZ_BYTE, 0, 32'h0,         32'hFFFF_FF80, 0);
    add("ld_sz3",   0, 32'h10, 2'b11,   0, 32'h0,         32'h8001_0000, 0);
    add("ld_h13",   0, 32'h13, SZ_HALF, 0, 32'h0,         ERR_EN ? 32'h0 : 32'hFFFF_8001, ERR_EN);
    add("ld_w12",   0, 32'h12, SZ_WORD, 0, 32'h0,         ERR_EN ? 32'h0 : 32'h8001_0000, ERR_EN);
    add("st_w14",   1, 32'h14, SZ_WORD, 0, 32'h1122_3344, 32'h0, 0);
    add("st_h16",   1, 32'h16, SZ_HALF, 0, 32'hFFFF_ABCD, 32'h0, 0);
    add("st_b14",   1, 32'h14, SZ_BYTE, 0, 32'h1234_5699, 32'h0, 0);
    add("ld_w14",   0, 32'h14, SZ_WORD, 0, 32'h0,         32'hABCD_3399, 0);
    add("st_oor",   1, 32'(DEPTH * 4), SZ_WORD, 0, 32'hCAFE_F00D, 32'h0, ERR_EN);
    add("ld_w0",    0, 32'h0,  SZ_WORD, 0, 32'h0,         ERR_EN ? 32'h0102_0304 : 32'hCAFE_F00D, 0);
    add("ld_oor",   0, 32'(DEPTH * 4 + 16), SZ_WORD, 0, 32'h0, ERR_EN ? 32'h0 : 32'h8001_0000, ERR_EN);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",  {31'b0, a_ready},  32'd0);
    check("rst_rvalid", {31'b0, a_rvalid}, 32'd0);
    check("rst_rdata",  a_rdata,           32'h0);
    check("rst_err",    {31'b0, a_err},    32'd0);
    check("rst_ready0", {31'b0, b_ready},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, a_ready},  32'd1);
    check("idle_rvalid", {31'b0, a_rvalid}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a store is in BUSY: the store must never commit.
    v.name = "st_w20"; v.we = 1; v.addr = 32'h20; v.size = SZ_WORD; v.uns = 0;
    v.wdata = 32'h1111_1111; v.exp_rdata = 32'h0; v.exp_err = 0;
    run_vec(v);
    @(negedge clk);
    v.wdata = 32'h1234_5678;
    drive_a(v);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check("busy_ready", {31'b0, a_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstbusy_ready", {31'b0, a_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstbusy_rvalid", {31'b0, a_rvalid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("postrst_rvalid", {31'b0, a_rvalid}, 32'd0);
      check("postrst_ready",  {31'b0, a_ready},  32'd1);
    end
    v.name = "ld_w20"; v.we = 0; v.wdata = 32'h0; v.exp_rdata = 32'h1111_1111;
    run_vec(v);

    // LATENCY=0: four requests with req_valid held high, one response per cycle.
    l0[0] = '{"l0_st_w40", 1, 32'h40, SZ_WORD, 0, 32'hA5A5_A5A5, 32'h0, 0};
    l0[1] = '{"l0_st_b41", 1, 32'h41, SZ_BYTE, 0, 32'h0000_003C, 32'h0, 0};
    l0[2] = '{"l0_ld_w40", 0, 32'h40, SZ_WORD, 0, 32'h0,         32'hA5A5_3CA5, 0};
    l0[3] = '{"l0_ld_b41", 0, 32'h41, SZ_BYTE, 1, 32'h0,         32'h0000_003C, 0};
    @(negedge clk);
    check("l0_idle_rvalid", {31'b0, b_rvalid}, 32'd0);
    drive_b(l0[0]);
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({l0[i].name, "_ready"},  {31'b0, b_ready},  32'd1);
      check({l0[i].name, "_rvalid"}, {31'b0, b_rvalid}, 32'd1);
      check({l0[i].name, "_rdata"},  b_rdata,           l0[i].exp_rdata);
      check({l0[i].name, "_err"},    {31'b0, b_err},    32'd0);
      if (i < 3) drive_b(l0[i+1]);
      else b_valid = 1'b0;
    end
    @(negedge clk);
    check("l0_end_rvalid", {31'b0, b_rvalid}, 32'd0);
    check("l0_end_rdata",  b_rdata,           32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
